// File: rtl/pong_pkg.sv
// Shared definitions for the pong game sequencer: FSM states, default
// screen/paddle geometry and small arithmetic helpers.
package pong_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SERVE,
      ST_PLAY,
      ST_POINT,
      ST_OVER
   } game_state_e;

   localparam int unsigned H_ACTIVE_DEF   = 640;
   localparam int unsigned V_ACTIVE_DEF   = 480;
   localparam int unsigned BALL_SIZE_DEF  = 8;
   localparam int unsigned PAD_HALF_DEF   = 20;
   localparam int unsigned PAD_L_FACE_DEF = 100;
   localparam int unsigned PAD_R_FACE_DEF = 540;

   // Top-left coordinate that puts a ball of edge 'size' in the middle of 'active'.
   function automatic logic [9:0] centre_pos(input int unsigned active, input int unsigned size);
      return 10'(active / 2 - size / 2);
   endfunction

   localparam logic [9:0] CENTRE_X = centre_pos(H_ACTIVE_DEF, BALL_SIZE_DEF);
   localparam logic [9:0] CENTRE_Y = centre_pos(V_ACTIVE_DEF, BALL_SIZE_DEF);

   function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] lim);
      return (s >= lim) ? lim : s + 4'd1;
   endfunction

endpackage

// File: rtl/pong_ball_step.sv
// Combinational one-frame ball advance: wall bounces, paddle bounces and
// miss detection from the current (pre-step) position and direction.
module pong_ball_step
   import pong_pkg::*;
#(
   parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
   parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
   parameter int unsigned BALL_SIZE  = BALL_SIZE_DEF,
   parameter int unsigned PAD_HALF   = PAD_HALF_DEF,
   parameter int unsigned PAD_L_FACE = PAD_L_FACE_DEF,
   parameter int unsigned PAD_R_FACE = PAD_R_FACE_DEF,
   parameter int unsigned SPEED      = 2
) (
   input  logic [9:0] ball_x_i,
   input  logic [9:0] ball_y_i,
   input  logic       dx_right_i,
   input  logic       dy_down_i,
   input  logic [9:0] left_y_i,
   input  logic [9:0] right_y_i,
   output logic [9:0] ball_x_o,
   output logic [9:0] ball_y_o,
   output logic       dx_right_o,
   output logic       dy_down_o,
   output logic       miss_o,
   output logic       left_scores_o
);

   localparam logic [10:0] HA = 11'(H_ACTIVE);
   localparam logic [10:0] VA = 11'(V_ACTIVE);
   localparam logic [10:0] BS = 11'(BALL_SIZE);
   localparam logic [10:0] PH = 11'(PAD_HALF);
   localparam logic [10:0] PL = 11'(PAD_L_FACE);
   localparam logic [10:0] PR = 11'(PAD_R_FACE);
   localparam logic [10:0] SP = 11'(SPEED);

   logic [10:0] x_w;
   logic [10:0] y_w;
   logic [10:0] ly_w;
   logic [10:0] ry_w;
   logic        ovl_l;
   logic        ovl_r;

   assign x_w  = {1'b0, ball_x_i};
   assign y_w  = {1'b0, ball_y_i};
   assign ly_w = {1'b0, left_y_i};
   assign ry_w = {1'b0, right_y_i};

   // Overlap written with additions only so a paddle near y=0 cannot underflow.
   assign ovl_l = (y_w + BS + PH > ly_w) && (y_w <= ly_w + PH);
   assign ovl_r = (y_w + BS + PH > ry_w) && (y_w <= ry_w + PH);

   always_comb begin
      ball_y_o  = ball_y_i;
      dy_down_o = dy_down_i;
      if (dy_down_i) begin
         if (y_w + BS + SP >= VA) begin
            ball_y_o  = 10'(VA - BS);
            dy_down_o = 1'b0;
         end else begin
            ball_y_o = 10'(y_w + SP);
         end
      end else if (y_w < SP) begin
         ball_y_o  = '0;
         dy_down_o = 1'b1;
      end else begin
         ball_y_o = 10'(y_w - SP);
      end
   end

   always_comb begin
      ball_x_o      = ball_x_i;
      dx_right_o    = dx_right_i;
      miss_o        = 1'b0;
      left_scores_o = 1'b0;
      if (dx_right_i) begin
         if ((x_w + BS <= PR) && (x_w + BS + SP >= PR) && ovl_r) begin
            ball_x_o   = 10'(PR - BS);
            dx_right_o = 1'b0;
         end else if (x_w + BS + SP >= HA) begin
            miss_o        = 1'b1;
            left_scores_o = 1'b1;
         end else begin
            ball_x_o = 10'(x_w + SP);
         end
      end else begin
         if ((x_w >= PL) && (x_w <= PL + SP) && ovl_l) begin
            ball_x_o   = 10'(PL);
            dx_right_o = 1'b1;
         end else if (x_w < SP) begin
            miss_o = 1'b1;
         end else begin
            ball_x_o = 10'(x_w - SP);
         end
      end
   end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve/play/point/over FSM, ball registers and score
// keeping, advancing the ball once per frame tick.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
   parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
   parameter int unsigned BALL_SIZE    = BALL_SIZE_DEF,
   parameter int unsigned PAD_HALF     = PAD_HALF_DEF,
   parameter int unsigned PAD_L_FACE   = PAD_L_FACE_DEF,
   parameter int unsigned PAD_R_FACE   = PAD_R_FACE_DEF,
   parameter int unsigned SPEED        = 2,
   parameter int unsigned WIN_SCORE    = 7,
   parameter int unsigned SERVE_FRAMES = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       start,
   input  logic [9:0] left_y,
   input  logic [9:0] right_y,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic [3:0] score_l,
   output logic [3:0] score_r,
   output logic       point,
   output logic       game_over
);

   localparam int unsigned  CNT_W    = $clog2(SERVE_FRAMES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
   localparam logic [3:0]   WIN      = 4'(WIN_SCORE);
   localparam logic [9:0]   CX       = centre_pos(H_ACTIVE, BALL_SIZE);
   localparam logic [9:0]   CY       = centre_pos(V_ACTIVE, BALL_SIZE);

   game_state_e      state_q, state_d;
   logic [9:0]       ball_x_q, ball_x_d;
   logic [9:0]       ball_y_q, ball_y_d;
   logic             dx_right_q, dx_right_d;
   logic             dy_down_q, dy_down_d;
   logic [3:0]       score_l_q, score_l_d;
   logic [3:0]       score_r_q, score_r_d;
   logic             point_q, point_d;
   logic             game_over_q, game_over_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic             left_scored_q, left_scored_d;

   logic [9:0] step_x, step_y;
   logic       step_dx_right, step_dy_down, step_miss, step_left_scores;
   logic [3:0] score_l_inc, score_r_inc;
   logic       scorer_wins;

   pong_ball_step #(
      .H_ACTIVE  (H_ACTIVE),
      .V_ACTIVE  (V_ACTIVE),
      .BALL_SIZE (BALL_SIZE),
      .PAD_HALF  (PAD_HALF),
      .PAD_L_FACE(PAD_L_FACE),
      .PAD_R_FACE(PAD_R_FACE),
      .SPEED     (SPEED)
   ) u_step (
      .ball_x_i     (ball_x_q),
      .ball_y_i     (ball_y_q),
      .dx_right_i   (dx_right_q),
      .dy_down_i    (dy_down_q),
      .left_y_i     (left_y),
      .right_y_i    (right_y),
      .ball_x_o     (step_x),
      .ball_y_o     (step_y),
      .dx_right_o   (step_dx_right),
      .dy_down_o    (step_dy_down),
      .miss_o       (step_miss),
      .left_scores_o(step_left_scores)
   );

   assign score_l_inc = sat_inc(score_l_q, WIN);
   assign score_r_inc = sat_inc(score_r_q, WIN);
   assign scorer_wins = left_scored_q ? (score_l_inc == WIN) : (score_r_inc == WIN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         ball_x_q      <= CX;
         ball_y_q      <= CY;
         dx_right_q    <= 1'b1;
         dy_down_q     <= 1'b1;
         score_l_q     <= '0;
         score_r_q     <= '0;
         point_q       <= 1'b0;
         game_over_q   <= 1'b0;
         frame_cnt_q   <= '0;
         left_scored_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ball_x_q      <= ball_x_d;
         ball_y_q      <= ball_y_d;
         dx_right_q    <= dx_right_d;
         dy_down_q     <= dy_down_d;
         score_l_q     <= score_l_d;
         score_r_q     <= score_r_d;
         point_q       <= point_d;
         game_over_q   <= game_over_d;
         frame_cnt_q   <= frame_cnt_d;
         left_scored_q <= left_scored_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_OVER: if (start) state_d = ST_SERVE;
         ST_SERVE:         if (frame_tick && frame_cnt_q == CNT_LAST) state_d = ST_PLAY;
         ST_PLAY:          if (frame_tick && step_miss) state_d = ST_POINT;
         ST_POINT:         state_d = scorer_wins ? ST_OVER : ST_SERVE;
         default:          state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ball_x_d      = ball_x_q;
      ball_y_d      = ball_y_q;
      dx_right_d    = dx_right_q;
      dy_down_d     = dy_down_q;
      score_l_d     = score_l_q;
      score_r_d     = score_r_q;
      point_d       = 1'b0;
      frame_cnt_d   = frame_cnt_q;
      left_scored_d = left_scored_q;
      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (start) begin
               score_l_d   = '0;
               score_r_d   = '0;
               frame_cnt_d = '0;
            end
         end
         ST_SERVE: begin
            if (frame_tick) frame_cnt_d = (frame_cnt_q == CNT_LAST) ? '0 : frame_cnt_q + CNT_W'(1);
         end
         ST_PLAY: begin
            // A miss freezes the ball where it is; POINT re-centres it next cycle.
            if (frame_tick) begin
               if (step_miss) begin
                  left_scored_d = step_left_scores;
               end else begin
                  ball_x_d   = step_x;
                  ball_y_d   = step_y;
                  dx_right_d = step_dx_right;
                  dy_down_d  = step_dy_down;
               end
            end
         end
         ST_POINT: begin
            if (left_scored_q) score_l_d = score_l_inc;
            else               score_r_d = score_r_inc;
            point_d     = 1'b1;
            ball_x_d    = CX;
            ball_y_d    = CY;
            dx_right_d  = left_scored_q;
            frame_cnt_d = '0;
         end
         default: ;
      endcase
      game_over_d = (state_d == ST_OVER);
   end

   assign ball_x    = ball_x_q;
   assign ball_y    = ball_y_q;
   assign score_l   = score_l_q;
   assign score_r   = score_r_q;
   assign point     = point_q;
   assign game_over = game_over_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomised scoreboard bench for pong_game_ctrl against a frame-level game model.
module tb_pong_game_ctrl;

   localparam int SCR_W = 640, SCR_H = 480, BALL = 8, PADH = 20;
   localparam int FACE_L = 100, FACE_R = 540, STEP = 2, WIN = 7, SERVE_N = 60;
   localparam int MID_X = SCR_W / 2 - BALL / 2;
   localparam int MID_Y = SCR_H / 2 - BALL / 2;
   localparam int BUDGET = 60000;

   localparam int PH_IDLE = 0, PH_SERVE = 1, PH_PLAY = 2, PH_POINT = 3, PH_OVER = 4;
   localparam int EV_NONE = 0, EV_RESET = 1, EV_START = 2, EV_PLAY = 3, EV_WALL = 4,
                  EV_HIT = 5, EV_MISS = 6, EV_POINT = 7;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic       start = 1'b0;
   logic [9:0] left_y = '0;
   logic [9:0] right_y = '0;
   logic [9:0] ball_x, ball_y;
   logic [3:0] score_l, score_r;
   logic       point, game_over;

   always #5 clk = ~clk;

   pong_game_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .frame_tick(frame_tick),
      .start     (start),
      .left_y    (left_y),
      .right_y   (right_y),
      .ball_x    (ball_x),
      .ball_y    (ball_y),
      .score_l   (score_l),
      .score_r   (score_r),
      .point     (point),
      .game_over (game_over)
   );

   typedef struct {
      int bx; int by; int sl; int sr; bit pt; bit go; int ev;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad = 0;
   bit   drv_done = 0;

   // Reference game state, kept in plain integers.
   int m_phase, m_bx, m_by, m_sl, m_sr, m_ticks;
   bit m_right, m_down, m_left_scored, m_pt;

   function automatic string ev_name(input int ev);
      case (ev)
         EV_RESET: return "reset";
         EV_START: return "start";
         EV_PLAY:  return "serve-done";
         EV_WALL:  return "wall-bounce";
         EV_HIT:   return "paddle-hit";
         EV_MISS:  return "miss";
         EV_POINT: return "point";
         default:  return "none";
      endcase
   endfunction

   function automatic bit covers(input int by, input int pad);
      return (by + BALL + PADH > pad) && (by <= pad + PADH);
   endfunction

   function automatic int pick_pad(input int by);
      int p;
      if ($urandom_range(0, 9) < 2) return int'($urandom_range(0, 30));
      p = by + 4 + int'($urandom_range(0, 160)) - 80;
      if (p < 0) p = 0;
      if (p > 1023) p = 1023;
      return p;
   endfunction

   task automatic model_reset();
      m_phase = PH_IDLE; m_bx = MID_X; m_by = MID_Y; m_sl = 0; m_sr = 0;
      m_ticks = 0; m_right = 1; m_down = 1; m_left_scored = 0; m_pt = 0;
   endtask

   task automatic frame_step(input int ly, input int ry, output int ev);
      int  ny, nx;
      bit  ndown, nright, miss, left_scores;
      ev = EV_NONE; miss = 0; left_scores = 0;
      ndown = m_down; nright = m_right;
      if (m_down) begin
         if (m_by + BALL + STEP >= SCR_H) begin ny = SCR_H - BALL; ndown = 0; ev = EV_WALL; end
         else ny = m_by + STEP;
      end else begin
         if (m_by < STEP) begin ny = 0; ndown = 1; ev = EV_WALL; end
         else ny = m_by - STEP;
      end
      if (m_right) begin
         if (m_bx + BALL <= FACE_R && m_bx + BALL + STEP >= FACE_R && covers(m_by, ry)) begin
            nx = FACE_R - BALL; nright = 0; ev = EV_HIT;
         end else if (m_bx + BALL + STEP >= SCR_W) begin
            miss = 1; left_scores = 1;
         end else nx = m_bx + STEP;
      end else begin
         if (m_bx >= FACE_L && m_bx - STEP <= FACE_L && covers(m_by, ly)) begin
            nx = FACE_L; nright = 1; ev = EV_HIT;
         end else if (m_bx < STEP) begin
            miss = 1;
         end else nx = m_bx - STEP;
      end
      if (miss) begin
         m_left_scored = left_scores; m_phase = PH_POINT; ev = EV_MISS;
      end else begin
         m_bx = nx; m_by = ny; m_right = nright; m_down = ndown;
      end
   endtask

   task automatic model_cycle(input bit tick, input bit st, input int ly, input int ry, output int ev);
      ev = EV_NONE;
      m_pt = 0;
      case (m_phase)
         PH_IDLE, PH_OVER: if (st) begin
            m_sl = 0; m_sr = 0; m_ticks = 0; m_phase = PH_SERVE; ev = EV_START;
         end
         PH_SERVE: if (tick) begin
            m_ticks++;
            if (m_ticks == SERVE_N) begin m_phase = PH_PLAY; m_ticks = 0; ev = EV_PLAY; end
         end
         PH_PLAY: if (tick) frame_step(ly, ry, ev);
         PH_POINT: begin
            if (m_left_scored) m_sl = (m_sl < WIN) ? m_sl + 1 : WIN;
            else               m_sr = (m_sr < WIN) ? m_sr + 1 : WIN;
            m_pt = 1; m_bx = MID_X; m_by = MID_Y; m_right = m_left_scored; m_ticks = 0;
            m_phase = (m_sl == WIN || m_sr == WIN) ? PH_OVER : PH_SERVE;
            ev = EV_POINT;
         end
         default: ;
      endcase
   endtask

   task automatic push_exp(input int ev);
      exp_t e;
      e.bx = m_bx; e.by = m_by; e.sl = m_sl; e.sr = m_sr;
      e.pt = m_pt; e.go = (m_phase == PH_OVER); e.ev = ev;
      sb_q.push_back(e);
   endtask

   // Driver: inputs change on the falling edge, expectation pushed for the next rising edge.
   initial begin
      int  games = 0;
      bit  did_reset = 0;
      bit  prev_tick = 0;
      int  ev;
      model_reset();
      for (int cyc = 0; cyc < BUDGET && games < 2; cyc++) begin
         @(negedge clk);
         frame_tick = !prev_tick && ($urandom_range(0, 3) != 0);
         prev_tick  = frame_tick;
         if (m_phase == PH_IDLE || m_phase == PH_OVER) start = ($urandom_range(0, 7) == 0);
         else start = ($urandom_range(0, 15) == 0);
         left_y  = 10'(pick_pad(m_by));
         right_y = 10'(pick_pad(m_by));
         if (cyc < 3) begin
            reset = 1'b1;
            model_reset();
            ev = EV_RESET;
         end else if (!did_reset && games == 1 && m_phase == PH_PLAY && m_sl + m_sr >= 2) begin
            // Short pulse between clock edges: only an asynchronous reset can catch it.
            reset = 1'b1;
            #2;
            reset = 1'b0;
            did_reset = 1;
            model_reset();
            model_cycle(frame_tick, start, int'(left_y), int'(right_y), ev);
            ev = EV_RESET;
         end else begin
            reset = 1'b0;
            model_cycle(frame_tick, start, int'(left_y), int'(right_y), ev);
         end
         if (ev == EV_POINT && m_phase == PH_OVER) games++;
         push_exp(ev);
      end
      if (games < 2 || !did_reset) begin
         total++; bad++;
         $display("FAIL progress: games_over=%0d mid_reset=%0b, required games_over=2 mid_reset=1",
                  games, did_reset);
      end
      drv_done = 1;
   end

   // Monitor: compares every registered output one time unit after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            total++;
            if (ball_x !== 10'(e.bx) || ball_y !== 10'(e.by) || score_l !== 4'(e.sl) ||
                score_r !== 4'(e.sr) || point !== e.pt || game_over !== e.go) begin
               bad++;
               $display("FAIL outputs(%s): got ball=(%0d,%0d) score=%0d:%0d point=%0b over=%0b, want ball=(%0d,%0d) score=%0d:%0d point=%0b over=%0b",
                        ev_name(e.ev), ball_x, ball_y, score_l, score_r, point, game_over,
                        e.bx, e.by, e.sl, e.sr, e.pt, e.go);
            end else if (e.ev != EV_NONE) begin
               $display("txn %-11s t=%0t ball=(%0d,%0d) score=%0d:%0d point=%0b over=%0b",
                        ev_name(e.ev), $time, ball_x, ball_y, score_l, score_r, point, game_over);
            end
         end
      end
   end

   initial begin
      wait (drv_done);
      repeat (3) @(posedge clk);
      #2;
      if (sb_q.size() != 0) begin
         total++; bad++;
         $display("FAIL drain: pending=%0d, required 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game sequencer for the pong display pipeline. Advances the ball once per video frame, bounces it off the top/bottom walls and both paddles, detects misses, keeps score and runs the serve/play/game-over state machine. Sits beside the paddle blocks: consumes their paddle centre positions and the frame tick from the vertical counter, and drives the ball position and scores to the pixel/colour logic.

## Interface
- `H_ACTIVE`, 640: visible width in pixels
- `V_ACTIVE`, 480: visible height in pixels
- `BALL_SIZE`, 8: ball edge length; ball position is its top-left pixel
- `PAD_HALF`, 20: paddle half-height around its centre y
- `PAD_L_FACE`, 100: x of the left paddle's right (hitting) face
- `PAD_R_FACE`, 540: x of the right paddle's left (hitting) face
- `SPEED`, 2: pixels moved per frame on each axis
- `WIN_SCORE`, 7: points that end a game
- `SERVE_FRAMES`, 60: frames the ball is held centred before play
- `clk` in 1: pixel clock
- `reset` in 1: asynchronous, active-high
- `frame_tick` in 1: one-cycle pulse at start of vertical blanking
- `start` in 1: level; starts or restarts a game
- `left_y` in 10: left paddle centre y
- `right_y` in 10: right paddle centre y
- `ball_x` out 10: ball left x
- `ball_y` out 10: ball top y
- `score_l` out 4: left player score
- `score_r` out 4: right player score
- `point` out 1: one-cycle pulse when a point is awarded
- `game_over` out 1: high in OVER

## Operation
- States: IDLE, SERVE, PLAY, POINT, OVER.
- IDLE: ball centred; `start`=1 -> clear scores, go SERVE.
- SERVE: ball centred; frame counter counts `frame_tick`s; after `SERVE_FRAMES` ticks -> PLAY.
- PLAY: on each `frame_tick` compute one step (below); miss -> POINT.
- POINT: one cycle; increment scorer's score, pulse `point`, re-centre ball, set dx toward the player who lost the point; scorer reaches `WIN_SCORE` -> OVER, else SERVE.
- OVER: ball centred, `game_over`=1, scores held; `start`=1 -> clear scores, SERVE.
- Centre: `ball_x` = H_ACTIVE/2 − BALL_SIZE/2 (316), `ball_y` = V_ACTIVE/2 − BALL_SIZE/2 (236).
- Step, y axis: moving down and `ball_y`+BALL_SIZE+SPEED ≥ V_ACTIVE -> `ball_y` = V_ACTIVE−BALL_SIZE, dy flips up; moving up and `ball_y` < SPEED -> `ball_y`=0, dy flips down; else ±SPEED.
- Step, x axis, moving right: if `ball_x`+BALL_SIZE ≤ PAD_R_FACE and `ball_x`+BALL_SIZE+SPEED ≥ PAD_R_FACE and paddle overlap -> `ball_x` = PAD_R_FACE−BALL_SIZE, dx flips; else if `ball_x`+BALL_SIZE+SPEED ≥ H_ACTIVE -> miss, left scores; else +SPEED.
- Moving left mirrors: face test `ball_x` ≥ PAD_L_FACE and `ball_x`−SPEED ≤ PAD_L_FACE -> `ball_x` = PAD_L_FACE, flip; `ball_x` < SPEED -> miss, right scores.
- Paddle overlap (no subtraction, no underflow): `ball_y`+BALL_SIZE+PAD_HALF > pad_y and `ball_y` ≤ pad_y+PAD_HALF. Uses the current (pre-step) `ball_y`.
- All sums in 11 bits unsigned.

## Timing
- Reset values: state IDLE, `ball_x`=316, `ball_y`=236, scores 0, `point`=0, `game_over`=0, dx=right, dy=down, frame counter 0.
- Outputs registered; a `frame_tick` in PLAY updates `ball_x`/`ball_y` on the next clock edge (latency 1).
- `frame_tick` outside PLAY moves nothing except the SERVE counter.
- Wall bounce and paddle bounce on the same tick: both applied.
- Wall bounce and miss on the same tick: miss wins; ball re-centred in POINT.
- `start` held high in SERVE/PLAY is ignored; only sampled in IDLE/OVER.
- Reset asserted mid-game: immediate return to reset values, no `point` pulse.
- Scores saturate at `WIN_SCORE`; never wrap.

## Structure
- `pong_pkg`: state enum, default geometry constants (640/480, paddle faces), centre-position localparams.
- Sub-module `pong_ball_step`: combinational next-position, next-direction and miss/hit flags from current position, direction and paddle y; controller holds all registers.

## Test plan
- Reset, `start`=1, 60 ticks -> PLAY entered after tick 60, ball at (316,236), dx right.
- Ball at y=470 moving down, tick -> `ball_y`=472, dy up; next tick -> 470.
- Ball x=530 moving right, `right_y`=240, `ball_y`=236, tick -> `ball_x`=532, dx left; same with `right_y`=100 -> passes, later miss, `score_l`=1, `point` pulses once.
- `left_y`=5 (near top), ball y=0 at left face -> bounce, no underflow false miss.
- Right player scores 7 -> `game_over`=1, ball centred, ticks ignored; `start` -> scores 0, SERVE.
- Assert `reset` in PLAY at ball (400,100) -> outputs return to reset values asynchronously.
